// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DISPLAY = 2'd1,
      BLANK   = 2'd2
   } scan_state_e;

   // Active-low segment bus with every segment and the dp dark
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low g..a patterns for hex 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg.sv
// Decodes one hex nibble into active-low g..a segment drive.
// Latency: purely combinational.
// Backpressure: none; output follows input continuously.
module hex_to_seg
   import hex_display_pkg::*;
(
   input  logic [3:0] hex_in,
   output logic [6:0] seg_out
);

   // Table lookup shared with the counter block
   always_comb begin
      seg_out = SEG_TABLE[hex_in];
   end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes one active-low segment bus across NUM_DIGITS anodes.
// Latency: an/seg/digit_idx/frame_tick are registered and match the state entered on the same edge.
// Backpressure: none; en=0 parks the scanner dark in IDLE on the next edge.
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int TICK_DIV      = 4,
   parameter int DISPLAY_TICKS = 3,
   parameter int BLANK_TICKS   = 1
) (
   input  logic                          clk_in,
   input  logic                          nReset,
   input  logic                          en,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          blank_lz,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [7:0]                    seg,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   scan_state_e             state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [15:0]             pre_q, pre_d;
   logic [15:0]             tick_q, tick_d;
   logic                    frame_q, frame_d;
   logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic                    snap_lz_q, snap_lz_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [7:0]              seg_q, seg_d;

   logic                    take_snap;
   logic                    tick_end;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic [6:0]              cur_seg;

   // Next-state logic: counters restart on every state entry so each window is exact
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pre_d     = pre_q;
      tick_d    = tick_q;
      frame_d   = 1'b0;
      take_snap = 1'b0;
      tick_end  = (pre_q == 16'(TICK_DIV - 1));

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = DISPLAY;
               idx_d     = '0;
               pre_d     = '0;
               tick_d    = '0;
               take_snap = 1'b1;
            end
         end
         DISPLAY, BLANK: begin
            if (tick_end && (tick_q == ((state_q == DISPLAY) ? 16'(DISPLAY_TICKS - 1)
                                                             : 16'(BLANK_TICKS - 1)))) begin
               pre_d  = '0;
               tick_d = '0;
               if ((state_q == DISPLAY) && (BLANK_TICKS != 0)) begin
                  state_d = BLANK;
               end else begin
                  state_d = DISPLAY;
                  if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                     // Frame wrap: only here are new inputs captured, so no tearing
                     idx_d     = '0;
                     frame_d   = 1'b1;
                     take_snap = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end else if (tick_end) begin
               pre_d  = '0;
               tick_d = tick_q + 16'd1;
            end else begin
               pre_d = pre_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!en) begin
         state_d   = IDLE;
         idx_d     = '0;
         pre_d     = '0;
         tick_d    = '0;
         frame_d   = 1'b0;
         take_snap = 1'b0;
      end
   end

   // Snapshot mux for the digits, dps and blanking mode shown this frame
   always_comb begin
      snap_dig_d = take_snap ? digits_in : snap_dig_q;
      snap_dp_d  = take_snap ? dp_in     : snap_dp_q;
      snap_lz_d  = take_snap ? blank_lz  : snap_lz_q;
   end

   // Leading-zero mask: walk down from the top digit until the first nonzero one
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run   = zero_run && (snap_dig_d[4*k +: 4] == 4'h0);
         lz_mask[k] = snap_lz_d && zero_run && (k != 0);
      end
   end

   assign cur_nib = snap_dig_d[{idx_d, 2'b00} +: 4];

   hex_to_seg u_dec (
      .hex_in  (cur_nib),
      .seg_out (cur_seg)
   );

   // Output drive computed from the state being entered, so the registers carry no extra latency
   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      if (state_d == DISPLAY) begin
         an_d[idx_d] = 1'b0;
         seg_d       = {~snap_dp_d[idx_d], lz_mask[idx_d] ? 7'h7F : cur_seg};
      end
   end

   // State, counter, snapshot and output registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (!nReset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         pre_q      <= '0;
         tick_q     <= '0;
         frame_q    <= 1'b0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         snap_lz_q  <= 1'b0;
         an_q       <= '1;
         seg_q      <= SEG_OFF;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
         frame_q    <= frame_d;
         snap_dig_q <= snap_dig_d;
         snap_dp_q  <= snap_dp_d;
         snap_lz_q  <= snap_lz_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign digit_idx  = idx_q;
   assign frame_tick = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: directed scenarios plus randomized traffic against a time-based model.
// Latency: model expects outputs to reflect the state entered on each edge.
// Backpressure: n/a.
module tb_hex_display_scanner;

   localparam int N     = 4;
   localparam int TD    = 4;
   localparam int DT    = 3;
   localparam int BT    = 1;
   localparam int PER   = (DT + BT) * TD;
   localparam int FRAME = N * PER;

   logic        clk_in    = 1'b0;
   logic        nReset    = 1'b0;
   logic        en        = 1'b0;
   logic [15:0] digits_in = 16'h0;
   logic [3:0]  dp_in     = 4'h0;
   logic        blank_lz  = 1'b0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference segment patterns, active-low g..a
   logic [6:0] ref_seg [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Model: time since the scan started, plus the frame's captured inputs
   bit          running = 1'b0;
   int          t       = 0;
   logic [15:0] m_dig   = 16'h0;
   logic [3:0]  m_dp    = 4'h0;
   logic        m_lz    = 1'b0;

   hex_display_scanner #(
      .NUM_DIGITS    (N),
      .TICK_DIV      (TD),
      .DISPLAY_TICKS (DT),
      .BLANK_TICKS   (BT)
   ) dut (
      .clk_in     (clk_in),
      .nReset     (nReset),
      .en         (en),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   // Advance one clock: update the model on the edge, compare at the falling edge
   task automatic cycle();
      int         d;
      int         off;
      bit         lit;
      bit         blanked;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      logic       e_ft;
      @(posedge clk_in);
      if (!nReset || !en) begin
         running = 1'b0;
         t       = 0;
      end else if (!running) begin
         running = 1'b1;
         t       = 0;
         m_dig   = digits_in;
         m_dp    = dp_in;
         m_lz    = blank_lz;
      end else begin
         t++;
         if (t % FRAME == 0) begin
            m_dig = digits_in;
            m_dp  = dp_in;
            m_lz  = blank_lz;
         end
      end
      @(negedge clk_in);
      d     = 0;
      e_an  = 4'hF;
      e_seg = 8'hFF;
      e_ft  = 1'b0;
      if (running) begin
         d   = (t / PER) % N;
         off = t % PER;
         lit = (off < DT * TD);
         e_ft = (t > 0) && (t % FRAME == 0);
         if (lit) begin
            blanked = m_lz && (d != 0) && ((m_dig >> (4 * d)) == 16'h0);
            e_an    = ~(4'b0001 << d);
            e_seg   = {~m_dp[d], blanked ? 7'h7F : ref_seg[m_dig[4*d +: 4]]};
         end
      end
      check("an", 16'(an), 16'(e_an));
      check("seg", 16'(seg), 16'(e_seg));
      check("digit_idx", 16'(digit_idx), 16'(d));
      check("frame_tick", 16'(frame_tick), 16'(e_ft));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      // Reset held with en=1
      nReset = 1'b0;
      en     = 1'b1;
      run(3);
      check("reset_an", 16'(an), 16'h000F);
      check("reset_seg", 16'(seg), 16'h00FF);

      // Scan order with 0A31
      digits_in = 16'h0A31;
      dp_in     = 4'h0;
      blank_lz  = 1'b0;
      nReset    = 1'b1;
      cycle();
      check("plan_first_an", 16'(an), 16'h000E);
      check("plan_first_seg", 16'(seg), 16'h00F9);
      run(FRAME + 8);

      // Leading-zero blanking on the same digits: restart for a fresh snapshot
      en = 1'b0;
      cycle();
      blank_lz = 1'b1;
      en       = 1'b1;
      run(FRAME + 4);

      // All-zero with blanking: only digit 0 lit
      digits_in = 16'h0000;
      run(FRAME);

      // Mid-frame change is not visible until the wrap
      blank_lz = 1'b0;
      run(20);
      digits_in = 16'hFFFF;
      run(2 * FRAME);

      // Decimal point on digit 1
      digits_in = 16'h0A31;
      dp_in     = 4'b0010;
      run(FRAME + 2);

      // Drop en mid-display of digit 2, then re-enable
      dp_in = 4'h0;
      while (!(running && ((t / PER) % N == 2) && (t % PER) == 3)) cycle();
      digits_in = 16'h1234;
      en        = 1'b0;
      cycle();
      check("en_drop_an", 16'(an), 16'h000F);
      check("en_drop_seg", 16'(seg), 16'h00FF);
      run(2);
      en = 1'b1;
      run(FRAME + 4);

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < 4; k++)
            digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         dp_in    = 4'($urandom_range(0, 15));
         blank_lz = 1'($urandom_range(0, 1));
         for (int c = 0; c < int'($urandom_range(20, 150)); c++) begin
            en     = ($urandom_range(0, 39) != 0);
            nReset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom_range(0, 15));
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexes one shared 8-bit segment bus across NUM_DIGITS hex digits. Each digit comes from a hex digit counter.
- Drives active-low digit enables in a fixed scan order. An anode-off blanking interval sits between digits to suppress ghosting.
- Sits between the counter bank and the board's common-anode seven-segment display.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- TICK_DIV, 4, clk_in cycles per scan tick (>=1)
- DISPLAY_TICKS, 3, ticks each digit is lit (>=1)
- BLANK_TICKS, 1, ticks all anodes off after each digit (0 = no blank state)

Ports:
- clk_in  input  1  system clock
- nReset  input  1  synchronous active-low reset
- en  input  1  scan enable; 0 = display dark
- digits_in  input  4*NUM_DIGITS  hex digits; digit k = bits [4k+3:4k]; digit 0 = rightmost
- dp_in  input  NUM_DIGITS  decimal point per digit, active-high
- blank_lz  input  1  leading-zero blanking enable
- an  output  NUM_DIGITS  digit enables, active-low
- seg  output  8  segments, active-low; bit7 = dp, bits6:0 = g..a
- digit_idx  output  $clog2(NUM_DIGITS)  index of current digit
- frame_tick  output  1  one-cycle pulse on wrap to digit 0

Behaviour:
- Reset is synchronous: nReset=0 sampled on a rising clk_in. Reset values:
  - state=IDLE, digit_idx=0, prescaler=0, tick count=0
  - an=all 1, seg=8'hFF, frame_tick=0, snapshot=0
- FSM states:
  - IDLE: an all 1, seg FF. If en=1 → DISPLAY with digit_idx=0; snapshot digits_in/dp_in/blank_lz on that same edge.
  - DISPLAY: an[digit_idx]=0, all others 1; seg = decode(snapshot digit). After exactly DISPLAY_TICKS*TICK_DIV cycles → BLANK, or → next digit if BLANK_TICKS=0.
  - BLANK: an all 1, seg FF for exactly BLANK_TICKS*TICK_DIV cycles. Then → DISPLAY with digit_idx+1.
- Wrap: digit_idx NUM_DIGITS-1 → 0.
  - On the wrapping transition, frame_tick=1 for one cycle.
  - A new snapshot is taken on that same edge. Inputs change only at frame boundaries, so there is no tearing.
- The prescaler and tick count clear on every state entry, so durations are exact.
  - Per-digit period = (DISPLAY_TICKS+BLANK_TICKS)*TICK_DIV cycles.
  - Frame = NUM_DIGITS × that.
- Outputs an/seg are registered and reflect the state entered on the same edge. No extra latency.
- Leading-zero blanking (blank_lz=1):
  - Scan from digit NUM_DIGITS-1 downward; zero digits are blanked until the first nonzero digit.
  - Digit 0 is never blanked.
  - A blanked digit has an asserted, seg[6:0]=7F, and dp still honoured.
- dp: seg[7] = ~dp (snapshot).
- en=0 while scanning: next edge → IDLE, outputs dark, digit_idx=0, counters cleared, frame_tick=0. en reasserted → restart at digit 0 with a fresh snapshot.
- nReset has priority over en.
- Decode (seg[6:0], active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Package hex_display_pkg: FSM state enum (IDLE, DISPLAY, BLANK), SEG_OFF=8'hFF, the 16-entry segment constant table.
- Sub-module hex_to_seg: combinational 4-bit → 7-bit active-low decode, shared with the counter block.

Test Plan (defaults: 16 cycles/digit, 64/frame):
- Reset: nReset=0 for 3 cycles with en=1 → an=4'hF, seg=FF, digit_idx=0, frame_tick=0.
- Scan order: en=1, digits_in=16'h0A31, dp_in=0, blank_lz=0.
  - 12 cycles: an=E, seg=F9; then 4 cycles: an=F, seg=FF.
  - Then an=D, seg=B0; then an=B, seg=88; then an=7, seg=C0.
  - frame_tick pulses at cycle 64.
- Leading-zero blanking: same stimulus with blank_lz=1 → digit 3 window shows an=7, seg=FF; digits 2..0 unchanged.
- Also with blank_lz=1: digits_in=0000 → only digit 0 shows C0.
- Snapshot: change digits_in to 16'hFFFF mid-frame → seg unchanged until after frame_tick; next frame all digits 8E.
- dp_in=4'b0010 → digit 1 window seg=30 (dp lit); all other digits have bit7=1.
- en dropped mid-DISPLAY of digit 2 → next cycle an=F, seg=FF. Re-enable → digit 0 lit with fresh snapshot; full 12-cycle window.
